ram_stream_reader: RTL
======================

Name: ram_stream_reader

Overview:
- Read-side companion to the team's single-port synchronous RAM block.
- Accepts a read command (start address, word count) and issues sequential reads to the RAM port.
- Registered RAM read data arrives one cycle after the address. The block returns it as an AXI-Stream-style burst with full backpressure support and tlast on the final word.
- Used to replay stored payload or header words into the RoCE TX datapath.

Parameters:
- DATA_WIDTH, 64, width of RAM word and stream data
- ADDR_WIDTH, 16, RAM address width
- LEN_WIDTH, 16, width of the command length field

Ports:
- clk  input  1  sole clock
- rst_n  input  1  synchronous active-low reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  block can accept a command
- cmd_addr  input  ADDR_WIDTH  first word address
- cmd_len  input  LEN_WIDTH  number of words minus 1
- mem_write_enable  output  1  RAM write enable, held 0
- mem_address  output  ADDR_WIDTH  RAM address
- mem_rd_en  output  1  high in cycles where mem_address is a real read issue
- mem_data_out  input  DATA_WIDTH  RAM registered read data, valid one cycle after issue
- m_axis_tdata  output  DATA_WIDTH  stream data
- m_axis_tvalid  output  1  stream valid
- m_axis_tready  input  1  stream ready
- m_axis_tlast  output  1  last word of burst
- busy  output  1  burst in progress (state != IDLE)
- done  output  1  one-cycle pulse when the final word is accepted downstream

Behaviour:
- Reset (rst_n low at a clk edge), outputs:
  - cmd_ready 0 during reset, 1 in the first cycle after release.
  - mem_address 0, mem_rd_en 0, mem_write_enable 0.
  - m_axis_tvalid 0, m_axis_tlast 0, m_axis_tdata 0.
  - busy 0, done 0.
- Reset, internal state: output FIFO, in-flight flag and counters are cleared.
- Reset mid-burst: the burst is abandoned, the in-flight read is discarded, and no partial tlast is emitted.

State machine:
- IDLE
  - cmd_ready=1.
  - On cmd_valid&cmd_ready: latch addr into rd_addr and cmd_len into remaining. Go to READ.
- READ
  - A read is issued when (fifo_count + inflight - pop) < 2, where pop = tvalid&tready this cycle.
  - On issue: mem_rd_en=1, mem_address=rd_addr, rd_addr increments, remaining decrements.
  - The issue with remaining==0 is tagged last. After it, go to DRAIN.
- DRAIN
  - No issues.
  - When the last-tagged word is popped, pulse done and go to IDLE.
  - cmd_ready rises the following cycle.

Datapath:
- inflight is a 1-bit register. It is set on issue and carries the last tag.
- The cycle after an issue, mem_data_out and the tag are pushed into a 2-entry output FIFO.
- The FIFO head drives m_axis_tdata and m_axis_tlast. m_axis_tvalid = FIFO non-empty.
- Pop on tvalid&tready. Simultaneous push and pop in the same cycle is legal and count-neutral.
- The issue rule guarantees the FIFO never overflows. Overflow is impossible by construction; an assertion checks it.

Timing and throughput:
- Cycle 0 is the command accept edge.
- First mem_rd_en is in cycle 1; first m_axis_tvalid is in cycle 3.
- With tready held 1, one word per cycle is sustained. A burst of N words finishes N+2 cycles after accept.

Stream rules:
- Once tvalid is asserted, tdata and tlast stay stable until accepted.
- tready low stalls issue within one cycle. No data is lost or duplicated.

Arithmetic and width:
- rd_addr increments modulo 2^ADDR_WIDTH: 0xFFFF wraps to 0x0000.
- cmd_len=0 means 1 word. cmd_len=all-ones means 2^LEN_WIDTH words.
- remaining is LEN_WIDTH bits and never underflows.

Other rules:
- mem_address holds its last value when mem_rd_en=0. Consumers ignore mem_data_out except in the cycle after mem_rd_en.
- cmd_valid while busy is ignored (cmd_ready=0). The command must be held until accepted.

Test Plan:
- Preload RAM[0x10..0x13]=A0..A3; cmd addr 0x10 len 3; tready=1 -> beats A0,A1,A2,A3 in cycles 3..6, tlast only on A3, done in cycle 6, cmd_ready=1 in cycle 7.
- cmd len 0 addr 0x20 (RAM=0xDEAD) -> single beat 0xDEAD with tlast=1; exactly one mem_rd_en pulse.
- 8-word burst with tready toggling 1,0,0,1,0,1,... -> all 8 words in order, none dropped or duplicated, tdata and tlast stable while stalled, fifo_count never exceeds 2.
- cmd addr 0xFFFE len 3 -> mem_address sequence FFFE, FFFF, 0000, 0001; data in that order.
- Two back-to-back commands with cmd_valid held high -> second accepted only after done; second burst's first tvalid is 3 cycles after its accept edge.
- rst_n low during word 3 of 6 -> next cycle tvalid=0, busy=0, cmd_ready=1 after release; a fresh command returns its correct data with no stale word from the aborted burst.

Source files
------------

// File: rtl/ram_stream_reader.sv
// Streams a run of consecutive words from a single-port synchronous RAM as a
// valid/ready burst with tlast on the final word and full backpressure support.
module ram_stream_reader #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 16,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic                  mem_write_enable,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_rd_en,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            dbg_state,
  output logic [1:0]            dbg_fifo_count
);

  // Handshakes: a transfer happens in a cycle where valid and ready are both
  // high at the rising edge; valid never waits on ready, and payload is held
  // stable while valid is high and ready is low.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [LEN_WIDTH-1:0]  r_remaining;
  logic                  r_inflight;
  logic                  r_inflight_last;
  logic [DATA_WIDTH-1:0] r_fifo_data [2];
  logic [1:0]            r_fifo_last;
  logic                  r_rd_ptr;
  logic                  r_wr_ptr;
  logic [1:0]            r_count;

  logic                  w_pop;
  logic                  w_push;
  logic                  w_accept;
  logic                  w_issue;
  logic                  w_issue_last;
  logic [2:0]            w_occupancy;

  // Words already buffered plus the one returning from the RAM, net of this
  // cycle's pop, must leave room for the word an issue now would produce.
  assign w_pop        = m_axis_tvalid & m_axis_tready;
  assign w_push       = r_inflight;
  assign w_occupancy  = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue      = (r_state == S_READ) && (w_occupancy < 3'd2);
  assign w_issue_last = w_issue && (r_remaining == '0);

  assign cmd_ready        = rst_n && (r_state == S_IDLE);
  assign w_accept         = cmd_valid && cmd_ready;
  assign mem_write_enable = 1'b0;
  assign mem_rd_en        = w_issue;
  assign mem_address      = w_issue ? r_rd_addr : r_mem_addr;

  assign m_axis_tvalid  = (r_count != 2'd0);
  assign m_axis_tdata   = r_fifo_data[r_rd_ptr];
  assign m_axis_tlast   = m_axis_tvalid & r_fifo_last[r_rd_ptr];
  assign done           = w_pop & m_axis_tlast;
  assign busy           = (r_state != S_IDLE);
  assign dbg_state      = r_state;
  assign dbg_fifo_count = r_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_rd_addr       <= '0;
      r_mem_addr      <= '0;
      r_remaining     <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      for (int i = 0; i < 2; i++) r_fifo_data[i] <= '0;
      r_fifo_last     <= 2'b00;
      r_rd_ptr        <= 1'b0;
      r_wr_ptr        <= 1'b0;
      r_count         <= 2'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_rd_addr   <= cmd_addr;
            r_remaining <= cmd_len;
            r_state     <= S_READ;
          end
        end
        S_READ: begin
          if (w_issue) begin
            r_mem_addr <= r_rd_addr;
            r_rd_addr  <= r_rd_addr + ADDR_WIDTH'(1);
            if (r_remaining == '0) r_state <= S_DRAIN;
            else r_remaining <= r_remaining - LEN_WIDTH'(1);
          end
        end
        S_DRAIN: begin
          if (done) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      r_inflight      <= w_issue;
      r_inflight_last <= w_issue_last;

      if (w_push) begin
        r_fifo_data[r_wr_ptr] <= mem_data_out;
        r_fifo_last[r_wr_ptr] <= r_inflight_last;
        r_wr_ptr              <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_push && !w_pop && (r_count == 2'd2)));

endmodule
